dmem_port_arbiter: RTL

Single-port data-memory arbiter between the load/store unit's load reads, ROB-committed stores and load/store-unit prefetch hints. It owns the one memory port.
- One transaction in flight at a time.
- Fixed priority: store > load > prefetch.
- Registered request/done handshakes toward each requester.
- Prefetch hints are buffered in a small deduplicating FIFO.

---
 rtl/dmem_port_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Owns the single data-memory port and arbitrates among ROB-committed
//   stores, load/store-unit load reads and buffered prefetch hints. Only one
//   transaction is in flight at a time, and priority is fixed as
//   store > load > prefetch.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   ld_req/ld_addr -> ld_done/ld_data load requester handshake and result
//   st_req/st_addr/st_data/st_mask    store requester, acked by st_done
//   pf_valid/pf_addr, pf_full         prefetch hint strobe, hint FIFO full
//   mem_req/we/addr/wdata/wmask       memory request, held until mem_ready
//   mem_ready/mem_rdata               memory completion and read data
module dmem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int PF_DEPTH   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld_req,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   output logic                  ld_done,
   output logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  st_req,
   input  logic [ADDR_WIDTH-1:0] st_addr,
   input  logic [DATA_WIDTH-1:0] st_data,
   input  logic [3:0]            st_mask,
   output logic                  st_done,
   input  logic                  pf_valid,
   input  logic [ADDR_WIDTH-1:0] pf_addr,
   output logic                  pf_full,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wmask,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int PW = $clog2(PF_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] STORE = 2'd1;
   localparam logic [1:0] LOAD  = 2'd2;
   localparam logic [1:0] PREF  = 2'd3;

   logic [1:0]            state;

   logic [ADDR_WIDTH-1:0] pf_mem [PF_DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         pf_count;

   logic                  st_q;
   logic                  ld_q;
   logic                  pf_empty;
   logic                  pf_dup;
   logic                  pf_push;
   logic                  pf_pop;
   logic [ADDR_WIDTH-1:0] pf_line;
   logic [ADDR_WIDTH-1:0] ld_line;

   // A requester still sees its own req high in the cycle done pulses;
   // masking it there prevents a second, duplicate transaction.
   assign st_q = st_req && !st_done;
   assign ld_q = ld_req && !ld_done;

   assign pf_line  = {pf_addr[ADDR_WIDTH-1:2], 2'b00};
   assign ld_line  = {ld_addr[ADDR_WIDTH-1:2], 2'b00};
   assign pf_empty = (pf_count == '0);
   assign pf_full  = (pf_count == CW'(PF_DEPTH));

   // The most recently pushed entry sits just below wr_ptr and is still
   // present whenever the FIFO is non-empty (pops remove the oldest first).
   assign pf_dup  = !pf_empty && (pf_mem[wr_ptr - PW'(1)] == pf_line);
   assign pf_push = pf_valid && !pf_full && !pf_dup;
   assign pf_pop  = (state == IDLE) && !st_q && !ld_q && !pf_empty;

   always_ff @(posedge clk) begin
      if (pf_push)
         pf_mem[wr_ptr] <= pf_line;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         pf_count <= '0;
      end else begin
         if (pf_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pf_pop)
            rd_ptr <= rd_ptr + PW'(1);
         pf_count <= pf_count + CW'(pf_push) - CW'(pf_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         ld_done   <= 1'b0;
         st_done   <= 1'b0;
         ld_data   <= '0;
      end else begin
         ld_done <= 1'b0;
         st_done <= 1'b0;
         case (state)
            IDLE: begin
               if (st_q) begin
                  state     <= STORE;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= st_addr;
                  mem_wdata <= st_data;
                  mem_wmask <= st_mask;
               end else if (ld_q) begin
                  state     <= LOAD;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= ld_line;
                  mem_wmask <= '0;
               end else if (!pf_empty) begin
                  state     <= PREF;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= pf_mem[rd_ptr];
                  mem_wmask <= '0;
               end
            end
            STORE, LOAD, PREF: begin
               if (mem_ready) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  if (state == STORE)
                     st_done <= 1'b1;
                  if (state == LOAD) begin
                     ld_done <= 1'b1;
                     ld_data <= mem_rdata;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
